// File: rtl/pwm_duty_decoder.sv
// PWM duty decoder: measures high time and period of a sampled PWM line in clk_en_i ticks
// and divides them into an ADC_BITWIDTH-bit duty. Optional macro: PWM_DEC_GLITCH_FILTER_EN.
//
// state      | meaning
// IDLE       | no period in progress; waiting for a rise (also after stuck-low)
// HIGH       | counting the high phase
// LOW        | counting the low phase; the next rise completes a measurement
// STUCK_HIGH | line held high past TIMEOUT; waiting for the fall
module pwm_duty_decoder #(
    parameter int ADC_BITWIDTH = 4,
    parameter int CNT_BITWIDTH = 5,
    parameter int TIMEOUT      = 30
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    clk_en_i,
    input  logic                    PWM_pin_i,
    output logic [ADC_BITWIDTH-1:0] duty_o,
    output logic [CNT_BITWIDTH-1:0] high_cnt_o,
    output logic [CNT_BITWIDTH:0]   period_cnt_o,
    output logic                    valid_o,
    output logic                    stuck_high_o,
    output logic                    stuck_low_o,
    output logic                    overrun_o
);
    localparam int PW     = CNT_BITWIDTH + 1;
    localparam int STEP_W = $clog2(ADC_BITWIDTH + 1);
    localparam logic [CNT_BITWIDTH-1:0] TIMEOUT_C = CNT_BITWIDTH'(TIMEOUT);
    localparam logic [CNT_BITWIDTH-1:0] CNT_MAX   = '1;
    localparam logic [CNT_BITWIDTH-1:0] CNT_ONE   = CNT_BITWIDTH'(1);
    localparam logic [STEP_W-1:0]       STEP_LAST = STEP_W'(ADC_BITWIDTH);
    localparam logic [STEP_W-1:0]       STEP_ONE  = STEP_W'(1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, STUCK_HIGH} state_t;
    state_t state, state_nxt;

    logic [1:0]              sync_q;
    logic                    pwm_sync, lvl, lvl_nxt, rise, fall;
    logic [CNT_BITWIDTH-1:0] cnt, cnt_nxt, cnt_inc, hi, hi_nxt;
    logic                    stuck_high_nxt, stuck_low_nxt, meas_done, stuck_evt;
    logic [ADC_BITWIDTH-1:0] stuck_duty;
    logic [PW-1:0]           meas_period;

    logic                    div_busy;
    logic [STEP_W-1:0]       div_step;
    logic [PW-1:0]           div_rem, rem_nxt, div_period;
    logic [PW:0]             rem_sh, per_ext;
    logic                    quo_bit;
    logic [ADC_BITWIDTH-1:0] div_quo;
    logic [CNT_BITWIDTH-1:0] div_high;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) sync_q <= '0;
        else         sync_q <= {sync_q[0], PWM_pin_i};
    end
    assign pwm_sync = sync_q[1];

`ifdef PWM_DEC_GLITCH_FILTER_EN
    logic diff_q;
    always_comb begin
        lvl_nxt = lvl;
        if ((pwm_sync != lvl) && diff_q) lvl_nxt = pwm_sync;
    end
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            lvl    <= 1'b0;
            diff_q <= 1'b0;
        end else if (clk_en_i) begin
            lvl    <= lvl_nxt;
            diff_q <= (pwm_sync != lvl) && !diff_q;
        end
    end
`else
    assign lvl_nxt = pwm_sync;
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)       lvl <= 1'b0;
        else if (clk_en_i) lvl <= lvl_nxt;
    end
`endif

    // Edges come from the level register's own update so the filter delays them too.
    assign rise        = lvl_nxt & ~lvl;
    assign fall        = ~lvl_nxt & lvl;
    assign cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    assign meas_period = {1'b0, hi} + {1'b0, cnt};

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state        <= IDLE;
            cnt          <= '0;
            hi           <= '0;
            stuck_high_o <= 1'b0;
            stuck_low_o  <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            hi           <= hi_nxt;
            stuck_high_o <= stuck_high_nxt;
            stuck_low_o  <= stuck_low_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        hi_nxt         = hi;
        stuck_high_nxt = stuck_high_o;
        stuck_low_nxt  = stuck_low_o;
        meas_done      = 1'b0;
        stuck_evt      = 1'b0;
        stuck_duty     = '0;
        if (clk_en_i) begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        state_nxt     = HIGH;
                        cnt_nxt       = CNT_ONE;
                        stuck_low_nxt = 1'b0;
                    end else begin
                        cnt_nxt = cnt_inc;
                        // cnt saturates above TIMEOUT, so this fires once per idle stretch
                        if ((cnt_inc == TIMEOUT_C) && (cnt != TIMEOUT_C)) begin
                            stuck_low_nxt = 1'b1;
                            stuck_evt     = 1'b1;
                        end
                    end
                end
                HIGH: begin
                    cnt_nxt = cnt_inc;
                    if (fall) begin
                        state_nxt = LOW;
                        hi_nxt    = cnt;
                        cnt_nxt   = CNT_ONE;
                    end else if (cnt_inc == TIMEOUT_C) begin
                        state_nxt      = STUCK_HIGH;
                        stuck_high_nxt = 1'b1;
                        stuck_evt      = 1'b1;
                        stuck_duty     = '1;
                    end
                end
                LOW: begin
                    cnt_nxt = cnt_inc;
                    if (rise) begin
                        meas_done = 1'b1;
                        state_nxt = HIGH;
                        cnt_nxt   = CNT_ONE;
                    end else if (cnt_inc == TIMEOUT_C) begin
                        state_nxt     = IDLE;
                        cnt_nxt       = TIMEOUT_C;
                        stuck_low_nxt = 1'b1;
                        stuck_evt     = 1'b1;
                    end
                end
                STUCK_HIGH: begin
                    if (fall) begin
                        state_nxt      = IDLE;
                        stuck_high_nxt = 1'b0;
                        cnt_nxt        = CNT_ONE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign rem_sh  = {div_rem, 1'b0};
    assign per_ext = {1'b0, div_period};
    assign quo_bit = (rem_sh >= per_ext);
    assign rem_nxt = quo_bit ? PW'(rem_sh - per_ext) : rem_sh[PW-1:0];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            div_busy     <= 1'b0;
            div_step     <= '0;
            div_rem      <= '0;
            div_quo      <= '0;
            div_high     <= '0;
            div_period   <= '0;
            duty_o       <= '0;
            high_cnt_o   <= '0;
            period_cnt_o <= '0;
            valid_o      <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (stuck_evt) begin
                duty_o   <= stuck_duty;
                valid_o  <= 1'b1;
                div_busy <= 1'b0;
            end else if (div_busy) begin
                if (div_step == STEP_LAST) begin
                    duty_o       <= div_quo;
                    high_cnt_o   <= div_high;
                    period_cnt_o <= div_period;
                    valid_o      <= 1'b1;
                    div_busy     <= 1'b0;
                end else begin
                    div_rem  <= rem_nxt;
                    div_quo  <= {div_quo[ADC_BITWIDTH-2:0], quo_bit};
                    div_step <= div_step + STEP_ONE;
                end
            end
            if (meas_done) begin
                if (div_busy) begin
                    overrun_o <= 1'b1;
                end else begin
                    div_busy   <= 1'b1;
                    div_step   <= '0;
                    div_rem    <= {1'b0, hi};
                    div_quo    <= '0;
                    div_high   <= hi;
                    div_period <= meas_period;
                end
            end
        end
    end
endmodule
